victim_cache_assoc: RTL and testbench
=====================================

Name: victim_cache_assoc

Overview:
Parametrised, fully-associative victim cache that sits between the L1 cache and L2/physical memory in the LC-3b memory hierarchy. It generalises the fixed victim cache to ENTRIES slots with true-LRU replacement, per-entry dirty tracking, and an atomic swap operation (read + evict in one request). Dirty LRU victims are written back to L2 before their slot is reused.

Parameters:
ENTRIES, 4, number of victim lines; power of 2, >= 2
TAG_W, 12, line tag width (address bits above the line offset)
OFFSET_W, 4, line offset bits; l2_address = {tag, OFFSET_W'b0}
LINE_W, 128, cache line width in bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
l1_read  in  1  request line l1_tag; held until mem_resp
l1_write  in  1  install evicted line; held until mem_resp
l1_tag  in  TAG_W  tag of the line requested by l1_read
tag  in  TAG_W  tag of the evicted line for l1_write
l1_wdata  in  LINE_W  evicted line data
dirty_in  in  1  evicted line dirty flag
l1_rdata  out  LINE_W  returned line (registered)
l1_dirty  out  1  dirty flag of the returned line
mem_resp  out  1  one-cycle completion pulse
l2_rdata  in  LINE_W  L2 read data
l2_mem_resp  in  1  L2 completion
l2_address  out  TAG_W+OFFSET_W  L2 line address
l2_wdata  out  LINE_W  write-back data
l2_read  out  1  L2 read request
l2_write  out  1  L2 write request

Behaviour:
- Reset: all valid = 0, dirty = 0, LRU order = index order, state IDLE. Outputs l1_rdata = 0, l1_dirty = 0, mem_resp = 0, l2_read = 0, l2_write = 0, l2_address = 0, l2_wdata = 0. A reset during FILL or WB aborts immediately: L2 strobes drop and contents are lost, including dirty lines.
- FSM states: IDLE, FILL, WB, DONE. Moore outputs; l2_read is high only in FILL, l2_write only in WB, and each is held until l2_mem_resp.
- Requests are sampled in IDLE only. In DONE, mem_resp = 1 for exactly one cycle, requests are ignored, and the FSM returns to IDLE.
- Read hit, read only:
  - IDLE -> DONE.
  - l1_rdata / l1_dirty take the entry's data and dirty flag.
  - Entry is invalidated; no other LRU ages change.
  - mem_resp rises the cycle after the request is first seen.
- Swap (read + write, read hits):
  - Hit entry is returned and overwritten in place with tag / l1_wdata / dirty_in, then marked MRU.
  - Same 1-cycle latency as a read hit; no L2 traffic.
- Read miss: IDLE -> FILL with l2_address = {l1_tag, 0}. On l2_mem_resp, l1_rdata = l2_rdata and l1_dirty = 0. Next state is DONE, or the install path if l1_write is also set.
- Install (l1_write; the read part, if any, is already resolved):
  - tag already present: overwrite that entry, dirty = old dirty | dirty_in.
  - else if an invalid slot exists: use the lowest-index invalid slot.
  - else take the LRU slot. If that slot is dirty, go to WB with l2_address = {victim tag, 0} and l2_wdata = victim data, and install on l2_mem_resp. If it is clean, install directly.
  - Installed entry becomes MRU. Next state is DONE.
- Maximum latency: FILL + WB + 1 cycle.
- LRU is true LRU: per-entry rank counters of width log2(ENTRIES). A touch moves the entry to MRU and increments every rank younger than it.
- At most one entry can match a tag, guaranteed by construction. l2_read and l2_write are never asserted together.

Optional Feature:
Macro VC_STATS_EN.
- Defined: adds output ports hit_count (16 bit) and miss_count (16 bit), saturating at 16'hFFFF and cleared by reset. One increment per l1_read request, counted at the IDLE decision.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Test Plan:
- Write-only fill, 4 clean lines, tags 0x001..0x004: each gives mem_resp 1 cycle after request, no l2_write.
- Then read tag 0x002: l1_rdata = stored line, mem_resp next cycle, entry invalidated. A second read of 0x002 misses and issues l2_read with l2_address = 0x0020.
- Fill 4 dirty lines, then write tag 0x010: l2_write with l2_address = LRU tag 0x001 << 4, its data on l2_wdata. After l2_mem_resp, mem_resp pulses and 0x010 is resident.
- Swap: read 0x003 + write 0x020 (dirty_in = 1): returns 0x003's data in 1 cycle with no L2 traffic; a later read of 0x020 hits with l1_dirty = 1.
- Read miss + write with cache full of dirty lines: l2_read, then l2_write in strict order; exactly one mem_resp.
- Assert rst_n = 0 mid-WB: l2_write drops asynchronously; afterwards every read misses. With VC_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/victim_cache_assoc.sv
// Fully-associative victim cache between L1 and L2 with true-LRU replacement,
// per-entry dirty tracking and an atomic swap (read hit + install in one request).
// Optional feature macro: VC_STATS_EN adds saturating hit_count / miss_count ports.
module victim_cache_assoc #(
    parameter int ENTRIES  = 4,
    parameter int TAG_W    = 12,
    parameter int OFFSET_W = 4,
    parameter int LINE_W   = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      l1_read,
    input  logic                      l1_write,
    input  logic [TAG_W-1:0]          l1_tag,
    input  logic [TAG_W-1:0]          tag,
    input  logic [LINE_W-1:0]         l1_wdata,
    input  logic                      dirty_in,
    output logic [LINE_W-1:0]         l1_rdata,
    output logic                      l1_dirty,
    output logic                      mem_resp,
    input  logic [LINE_W-1:0]         l2_rdata,
    input  logic                      l2_mem_resp,
    output logic [TAG_W+OFFSET_W-1:0] l2_address,
    output logic [LINE_W-1:0]         l2_wdata,
    output logic                      l2_read,
    output logic                      l2_write
`ifdef VC_STATS_EN
    ,
    output logic [15:0]               hit_count,
    output logic [15:0]               miss_count
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, FILL, WB, DONE} state_t;
    state_t state, state_nxt;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] dirty;
    logic [TAG_W-1:0]   tags  [ENTRIES];
    logic [LINE_W-1:0]  lines [ENTRIES];
    // rank 0 = most recently used, ENTRIES-1 = least recently used
    logic [IDX_W-1:0]   rank  [ENTRIES];

    logic             r_hit, w_hit, inv_any, need_wb;
    logic [IDX_W-1:0] r_idx, w_idx, inv_idx, lru_idx, ins_idx, tch_idx;
    logic             rd_hit_en, swap_en, inval_en, fill_req_en, fill_cap_en, wb_req_en, ins_en;

    // Tag lookups, lowest invalid slot, LRU slot and the resulting install target
    always_comb begin
        r_hit   = 1'b0;
        w_hit   = 1'b0;
        inv_any = 1'b0;
        r_idx   = '0;
        w_idx   = '0;
        inv_idx = '0;
        lru_idx = '0;
        // descending scan so the lowest-index invalid slot is the one kept
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == l1_tag) begin
                r_hit = 1'b1;
                r_idx = IDX_W'(i);
            end
            if (valid[i] && tags[i] == tag) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
            if (rank[i] == IDX_W'(ENTRIES - 1)) lru_idx = IDX_W'(i);
        end
        ins_idx = w_hit ? w_idx : (inv_any ? inv_idx : lru_idx);
        need_wb = !w_hit && !inv_any && dirty[lru_idx];
        tch_idx = swap_en ? r_idx : ins_idx;
    end

    // State register; a reset aborts any L2 transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and datapath action strobes
    always_comb begin
        state_nxt   = state;
        rd_hit_en   = 1'b0;
        swap_en     = 1'b0;
        inval_en    = 1'b0;
        fill_req_en = 1'b0;
        fill_cap_en = 1'b0;
        wb_req_en   = 1'b0;
        ins_en      = 1'b0;
        case (state)
            IDLE: begin
                if (l1_read) begin
                    if (r_hit) begin
                        rd_hit_en = 1'b1;
                        swap_en   = l1_write;
                        inval_en  = !l1_write;
                        state_nxt = DONE;
                    end else begin
                        fill_req_en = 1'b1;
                        state_nxt   = FILL;
                    end
                end else if (l1_write) begin
                    if (need_wb) begin
                        wb_req_en = 1'b1;
                        state_nxt = WB;
                    end else begin
                        ins_en    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            FILL: begin
                if (l2_mem_resp) begin
                    fill_cap_en = 1'b1;
                    state_nxt   = DONE;
                    if (l1_write) begin
                        if (need_wb) begin
                            wb_req_en = 1'b1;
                            state_nxt = WB;
                        end else begin
                            ins_en = 1'b1;
                        end
                    end
                end
            end
            WB: begin
                if (l2_mem_resp) begin
                    ins_en    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign l2_read  = (state == FILL);
    assign l2_write = (state == WB);
    assign mem_resp = (state == DONE);

    // Entry storage, LRU ranks and registered L1/L2 data paths
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            dirty      <= '0;
            l1_rdata   <= '0;
            l1_dirty   <= 1'b0;
            l2_address <= '0;
            l2_wdata   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]  <= '0;
                lines[i] <= '0;
                rank[i]  <= IDX_W'(i);
            end
        end else begin
            if (rd_hit_en) begin
                l1_rdata <= lines[r_idx];
                l1_dirty <= dirty[r_idx];
            end
            if (fill_cap_en) begin
                l1_rdata <= l2_rdata;
                l1_dirty <= 1'b0;
            end
            // a plain read hit hands the line back to L1 and frees the slot
            if (inval_en) valid[r_idx] <= 1'b0;
            if (fill_req_en) l2_address <= {l1_tag, {OFFSET_W{1'b0}}};
            if (wb_req_en) begin
                l2_address <= {tags[lru_idx], {OFFSET_W{1'b0}}};
                l2_wdata   <= lines[lru_idx];
            end
            if (swap_en || ins_en) begin
                tags[tch_idx]  <= tag;
                lines[tch_idx] <= l1_wdata;
                valid[tch_idx] <= 1'b1;
                // re-installing a resident tag must not lose its dirty state
                dirty[tch_idx] <= (ins_en && w_hit) ? (dirty[tch_idx] | dirty_in) : dirty_in;
                for (int i = 0; i < ENTRIES; i++) begin
                    if (IDX_W'(i) == tch_idx)        rank[i] <= '0;
                    else if (rank[i] < rank[tch_idx]) rank[i] <= rank[i] + IDX_W'(1);
                end
            end
        end
    end

`ifdef VC_STATS_EN
    // Saturating per-request hit/miss counters, sampled at the IDLE decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && l1_read) begin
            if (r_hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else if (miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_victim_cache_assoc.sv
`timescale 1ns/1ps
module tb_victim_cache_assoc;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         l1_read = 1'b0, l1_write = 1'b0, dirty_in = 1'b0;
    logic [11:0]  l1_tag = '0, tag = '0;
    logic [127:0] l1_wdata = '0;
    logic [127:0] l1_rdata;
    logic         l1_dirty, mem_resp;
    logic [127:0] l2_rdata = '0;
    logic         l2_mem_resp = 1'b0;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_read, l2_write;
`ifdef VC_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    // per-request observations
    int           n_cyc, n_resp, rd_first, wr_first, l2_wait;
    logic         done, rd_seen, wr_seen, both;
    logic [15:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;

    victim_cache_assoc dut (
        .clk(clk), .rst_n(rst_n),
        .l1_read(l1_read), .l1_write(l1_write), .l1_tag(l1_tag), .tag(tag),
        .l1_wdata(l1_wdata), .dirty_in(dirty_in),
        .l1_rdata(l1_rdata), .l1_dirty(l1_dirty), .mem_resp(mem_resp),
        .l2_rdata(l2_rdata), .l2_mem_resp(l2_mem_resp), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write)
`ifdef VC_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input logic [11:0] t, input logic [3:0] g);
        mk = {4{g, t, 16'hC0DE}};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // L2 model: answers each strobe on its third observed cycle with a one-cycle response
    initial begin
        l2_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            l2_mem_resp = 1'b0;
            if (l2_read || l2_write) begin
                l2_wait++;
                if (l2_wait == 3) begin
                    l2_mem_resp = 1'b1;
                    l2_rdata    = {8{l2_address}};
                    l2_wait     = 0;
                end
            end else begin
                l2_wait = 0;
            end
        end
    end

    task automatic run_req(input logic rd, input logic wr, input logic [11:0] rt,
                           input logic [11:0] wt, input logic [127:0] wd, input logic di);
        l1_read = rd; l1_write = wr; l1_tag = rt; tag = wt; l1_wdata = wd; dirty_in = di;
        n_cyc = 0; n_resp = 0; done = 0; rd_seen = 0; wr_seen = 0; both = 0;
        rd_first = 0; wr_first = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (!done && n_cyc < 40) begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (l2_read && !rd_seen) begin rd_seen = 1; rd_first = n_cyc; rd_addr = l2_address; end
            if (l2_write && !wr_seen) begin
                wr_seen = 1; wr_first = n_cyc; wr_addr = l2_address; wr_data = l2_wdata;
            end
            if (l2_read && l2_write) both = 1;
            if (mem_resp) begin n_resp++; done = 1; end
        end
        l1_read = 0; l1_write = 0; dirty_in = 0;
        chk("no_timeout", 128'(done), 128'(1));
        @(posedge clk);
        #1;
        if (mem_resp) n_resp++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        chk("rst_l2_strobes", 128'({l2_read, l2_write, mem_resp}), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mem_resp", 128'(mem_resp), 128'(0));
        chk("rst_l2_rw", 128'({l2_read, l2_write}), 128'(0));
        chk("rst_l2_address", 128'(l2_address), 128'(0));
        chk("rst_l2_wdata", l2_wdata, 128'(0));
        chk("rst_l1_out", {l1_rdata[126:0], l1_dirty}, 128'(0));

        // four clean installs, tags 1..4 into slots 0..3
        for (int t = 1; t <= 4; t++) begin
            run_req(0, 1, '0, 12'(t), mk(12'(t), 4'h1), 0);
            chk("wfill_lat", 128'(n_cyc), 128'(1));
            chk("wfill_no_l2", 128'({rd_seen, wr_seen}), 128'(0));
            chk("wfill_one_resp", 128'(n_resp), 128'(1));
        end

        run_req(1, 0, 12'h002, '0, '0, 0);
        chk("rhit_data", l1_rdata, mk(12'h002, 4'h1));
        chk("rhit_dirty", 128'(l1_dirty), 128'(0));
        chk("rhit_lat", 128'(n_cyc), 128'(1));
        chk("rhit_no_l2", 128'({rd_seen, wr_seen}), 128'(0));

        run_req(1, 0, 12'h002, '0, '0, 0);
        chk("rmiss_l2_read", 128'(rd_seen), 128'(1));
        chk("rmiss_addr", 128'(rd_addr), 128'(16'h0020));
        chk("rmiss_lat", 128'(n_cyc), 128'(4));
        chk("rmiss_data", l1_rdata, {8{16'h0020}});
        chk("rmiss_dirty", 128'(l1_dirty), 128'(0));
        chk("rmiss_no_wb", 128'(wr_seen), 128'(0));

        // dirty refill: tags 1,3,4 merge in place, tag 2 takes freed slot 1
        for (int t = 1; t <= 4; t++) begin
            run_req(0, 1, '0, 12'(t), mk(12'(t), 4'h2), 1);
            chk("dfill_lat", 128'(n_cyc), 128'(1));
            chk("dfill_no_l2", 128'({rd_seen, wr_seen}), 128'(0));
        end

        // full of dirty lines: LRU is tag 1 in slot 0
        run_req(0, 1, '0, 12'h010, mk(12'h010, 4'h3), 1);
        chk("evict_wb", 128'(wr_seen), 128'(1));
        chk("evict_addr", 128'(wr_addr), 128'(16'h0010));
        chk("evict_data", wr_data, mk(12'h001, 4'h2));
        chk("evict_lat", 128'(n_cyc), 128'(4));
        chk("evict_one_resp", 128'(n_resp), 128'(1));
        chk("evict_no_read", 128'(rd_seen), 128'(0));

        // rewrite of resident tag 0x010 clean: no eviction, dirty kept by merge
        run_req(0, 1, '0, 12'h010, mk(12'h010, 4'h3), 0);
        chk("resident_lat", 128'(n_cyc), 128'(1));
        chk("resident_no_wb", 128'(wr_seen), 128'(0));

        run_req(1, 1, 12'h003, 12'h020, mk(12'h020, 4'h4), 1);
        chk("swap_data", l1_rdata, mk(12'h003, 4'h2));
        chk("swap_dirty", 128'(l1_dirty), 128'(1));
        chk("swap_lat", 128'(n_cyc), 128'(1));
        chk("swap_no_l2", 128'({rd_seen, wr_seen}), 128'(0));

        run_req(1, 0, 12'h020, '0, '0, 0);
        chk("swap_read_data", l1_rdata, mk(12'h020, 4'h4));
        chk("swap_read_dirty", 128'(l1_dirty), 128'(1));
        chk("swap_read_lat", 128'(n_cyc), 128'(1));

        run_req(0, 1, '0, 12'h030, mk(12'h030, 4'h5), 1);
        chk("refill_lat", 128'(n_cyc), 128'(1));

        // read miss + install into a full dirty cache: LRU is tag 2 in slot 1
        run_req(1, 1, 12'h100, 12'h040, mk(12'h040, 4'h6), 1);
        chk("mw_read", 128'(rd_seen), 128'(1));
        chk("mw_read_addr", 128'(rd_addr), 128'(16'h1000));
        chk("mw_write", 128'(wr_seen), 128'(1));
        chk("mw_wb_addr", 128'(wr_addr), 128'(16'h0020));
        chk("mw_wb_data", wr_data, mk(12'h002, 4'h2));
        chk("mw_order", 128'(rd_first < wr_first), 128'(1));
        chk("mw_exclusive", 128'(both), 128'(0));
        chk("mw_one_resp", 128'(n_resp), 128'(1));
        chk("mw_lat", 128'(n_cyc), 128'(7));
        chk("mw_data", l1_rdata, {8{16'h1000}});
        chk("mw_dirty", 128'(l1_dirty), 128'(0));

        run_req(1, 0, 12'h010, '0, '0, 0);
        chk("merge_data", l1_rdata, mk(12'h010, 4'h3));
        chk("merge_dirty", 128'(l1_dirty), 128'(1));

        run_req(0, 1, '0, 12'h060, mk(12'h060, 4'h8), 1);
        chk("fill60_lat", 128'(n_cyc), 128'(1));

        // start an eviction of LRU tag 4 and reset in the middle of WB
        l1_write = 1; tag = 12'h050; l1_wdata = mk(12'h050, 4'h7); dirty_in = 1;
        n_cyc = 0; wr_seen = 0;
        while (!wr_seen && n_cyc < 20) begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (l2_write) wr_seen = 1;
        end
        chk("rwb_seen", 128'(wr_seen), 128'(1));
        chk("rwb_addr", 128'(l2_address), 128'(16'h0040));
        chk("rwb_data", l2_wdata, mk(12'h004, 4'h2));
        #2 rst_n = 1'b0;
        #1;
        chk("rwb_write_drop", 128'(l2_write), 128'(0));
        chk("rwb_addr_clear", 128'(l2_address), 128'(0));
        l1_write = 0; dirty_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
`ifdef VC_STATS_EN
        #1;
        chk("stats_hit_zero", 128'(hit_count), 128'(0));
        chk("stats_miss_zero", 128'(miss_count), 128'(0));
`endif
        run_req(1, 0, 12'h030, '0, '0, 0);
        chk("post_rst_miss_030", 128'(rd_seen), 128'(1));
        chk("post_rst_addr_030", 128'(rd_addr), 128'(16'h0300));
        run_req(1, 0, 12'h040, '0, '0, 0);
        chk("post_rst_miss_040", 128'(rd_seen), 128'(1));
        run_req(1, 0, 12'h004, '0, '0, 0);
        chk("post_rst_miss_004", 128'(rd_seen), 128'(1));
        chk("post_rst_lat", 128'(n_cyc), 128'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
